// File: rtl/mem_join_pkg.sv
// Shared definitions for the N-channel memory-handshake join (mem_join_ctrl).
// The optional watchdog is enabled by defining MEM_JOIN_TIMEOUT_EN.
package mem_join_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    ACK  = ST_ACK
  } state_e;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_join_ch.sv
// One join channel: bus request gating, completion flag and read-data capture.
// Part of mem_join_ctrl (optional watchdog: MEM_JOIN_TIMEOUT_EN, handled in the top).
module mem_join_ch
  import mem_join_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  state_e            state_i,
  input  logic              go_wait_i,
  input  logic              cpu_req_i,
  input  logic              mask_i,
  input  logic              bus_ready_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_req_o,
  output logic              hit_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  logic              done_q;
  logic [DATA_W-1:0] data_q;

  // A finished channel drops its request while the others are still pending.
  always_comb begin
    bus_req_o = 1'b0;
    case (state_i)
      IDLE:    bus_req_o = cpu_req_i;
      WAIT:    bus_req_o = mask_i & ~done_q;
      default: bus_req_o = 1'b0;
    endcase
  end

  assign hit_o  = bus_req_o & bus_ready_i;
  assign done_o = done_q;
  assign data_o = data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      case (state_i)
        IDLE: begin
          // Unfinished channels start from zero so a watchdog abort returns 0.
          if (go_wait_i) begin
            done_q <= hit_o;
            data_q <= hit_o ? bus_rdata_i : '0;
          end
        end
        WAIT: begin
          if (hit_o) begin
            done_q <= 1'b1;
            data_q <= bus_rdata_i;
          end
        end
        ACK:     done_q <= 1'b0;
        default: done_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_join_ctrl.sv
// N-channel memory-handshake join: stalls the CPU until every requested bus channel completes.
// Define MEM_JOIN_TIMEOUT_EN to add a watchdog that forces ACK with err_o after TO_CYCLES.
module mem_join_ctrl
  import mem_join_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          cpu_req_i,
  output logic [N_CH*DATA_W-1:0]   cpu_rdata_o,
  output logic                     mem_ready_o,
  output logic                     err_o,
  output logic [N_CH-1:0]          bus_req_o,
  input  logic [N_CH-1:0]          bus_ready_i,
  input  logic [N_CH*DATA_W-1:0]   bus_rdata_i
);

  state_e                  state_q;
  logic [N_CH-1:0]         mask_q;
  logic [N_CH-1:0]         req_raw;
  logic [N_CH-1:0]         hit;
  logic [N_CH-1:0]         done;
  logic [N_CH*DATA_W-1:0]  data_flat;
  logic                    ok;
  logic                    go_wait;
  logic                    all_done;
  logic                    expire;

  assign ok       = &(bus_ready_i | ~cpu_req_i);
  assign go_wait  = (state_q == IDLE) & ~ok;
  assign all_done = &(~mask_q | done | hit);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    mem_join_ch #(.DATA_W(DATA_W)) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .state_i     (state_q),
      .go_wait_i   (go_wait),
      .cpu_req_i   (cpu_req_i[k]),
      .mask_i      (mask_q[k]),
      .bus_ready_i (bus_ready_i[k]),
      .bus_rdata_i (bus_rdata_i[k*DATA_W +: DATA_W]),
      .bus_req_o   (req_raw[k]),
      .hit_o       (hit[k]),
      .done_o      (done[k]),
      .data_o      (data_flat[k*DATA_W +: DATA_W])
    );
  end

`ifdef MEM_JOIN_TIMEOUT_EN
  localparam int CNT_W = clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign expire = (cnt_q == CNT_W'(TO_CYCLES - 1));
  assign err_o  = rst_i & (state_q == ACK) & err_q;
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES == 0);
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
`ifdef MEM_JOIN_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!ok) begin
            state_q <= WAIT;
            mask_q  <= cpu_req_i;
`ifdef MEM_JOIN_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        WAIT: begin
`ifdef MEM_JOIN_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          // A completion on the terminal watchdog cycle still counts as success.
          if (all_done) begin
            state_q <= ACK;
`ifdef MEM_JOIN_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end else if (expire) begin
            state_q <= ACK;
`ifdef MEM_JOIN_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req_o   = rst_i ? req_raw : '0;
  assign mem_ready_o = rst_i & (((state_q == IDLE) & ok) | (state_q == ACK));
  assign cpu_rdata_o = (state_q == IDLE) ? bus_rdata_i : data_flat;

endmodule

// File: tb/tb_mem_join_ctrl.sv
// Randomized and directed bench for mem_join_ctrl against a transaction-level reference model.
// Build with MEM_JOIN_TIMEOUT_EN defined to also cover the watchdog path.
module tb_mem_join_ctrl;
  import mem_join_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;
`ifdef MEM_JOIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic [N-1:0]     cpu_req_i;
  logic [N*W-1:0]   cpu_rdata_o;
  logic             mem_ready_o;
  logic             err_o;
  logic [N-1:0]     bus_req_o;
  logic [N-1:0]     bus_ready_i;
  logic [N*W-1:0]   bus_rdata_i;

  mem_join_ctrl #(.N_CH(N), .DATA_W(W), .TO_CYCLES(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_ready_o (mem_ready_o),
    .err_o       (err_o),
    .bus_req_o   (bus_req_o),
    .bus_ready_i (bus_ready_i),
    .bus_rdata_i (bus_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one outstanding CPU transaction, tracked as a set of pending channels.
  bit           m_busy, m_ack, m_err;
  bit [N-1:0]   m_mask, m_pend;
  bit [W-1:0]   m_data [N];
  int           m_wait_cycles;

  function automatic void model_reset();
    m_busy = 0; m_ack = 0; m_err = 0; m_mask = '0; m_pend = '0; m_wait_cycles = 0;
  endfunction

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] rdy, input logic [N*W-1:0] rd);
    logic [N-1:0] exp_req;
    logic         exp_rdy;
    logic         exp_err;
    @(negedge clk);
    cpu_req_i   = req;
    bus_ready_i = rdy;
    bus_rdata_i = rd;
    #1;
    if (m_ack) begin
      exp_req = '0; exp_rdy = 1'b1; exp_err = m_err;
    end else if (m_busy) begin
      exp_req = m_pend; exp_rdy = 1'b0; exp_err = 1'b0;
    end else begin
      exp_req = req; exp_rdy = &(rdy | ~req); exp_err = 1'b0;
    end
    chk("bus_req", 64'(bus_req_o), 64'(exp_req));
    chk("mem_ready", 64'(mem_ready_o), 64'(exp_rdy));
    chk("err", 64'(err_o), 64'(exp_err));
    for (int k = 0; k < N; k++) begin
      if (m_ack && m_mask[k])
        chk($sformatf("ack_rdata%0d", k), 64'(cpu_rdata_o[k*W +: W]), 64'(m_data[k]));
      else if (!m_ack && !m_busy)
        chk($sformatf("idle_rdata%0d", k), 64'(cpu_rdata_o[k*W +: W]), 64'(rd[k*W +: W]));
    end
    // Advance the model to what the coming rising edge should produce.
    if (m_ack) begin
      m_ack = 0; m_busy = 0;
    end else if (m_busy) begin
      for (int k = 0; k < N; k++)
        if (m_pend[k] && rdy[k]) begin
          m_data[k] = rd[k*W +: W];
          m_pend[k] = 1'b0;
        end
      m_wait_cycles++;
      if (m_pend == '0) begin
        m_ack = 1; m_err = 0;
      end else if (TO_EN && m_wait_cycles == TO) begin
        m_ack = 1; m_err = 1;
      end
    end else if (!(&(rdy | ~req))) begin
      m_busy = 1; m_mask = req; m_pend = req & ~rdy; m_wait_cycles = 0;
      for (int k = 0; k < N; k++)
        m_data[k] = (req[k] && rdy[k]) ? rd[k*W +: W] : '0;
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = $urandom;
    return d;
  endfunction

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   r;
    model_reset();
    rst_i       = 1'b0;
    cpu_req_i   = '1;
    bus_ready_i = '1;
    bus_rdata_i = '0;
    #2;
    chk("rst_bus_req", 64'(bus_req_o), 64'(0));
    chk("rst_mem_ready", 64'(mem_ready_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;

    // Zero-latency path: every request ready in the same cycle.
    step(4'b0011, 4'b0011, rand_data());
    step(4'b0000, 4'b0000, rand_data());

    // Staggered completion: ch0 at once, ch1 three cycles later.
    d = rand_data();
    step(4'b0011, 4'b0001, d);
    step(4'b0011, 4'b0000, rand_data());
    step(4'b0011, 4'b0000, rand_data());
    d = rand_data(); d[W +: W] = 32'hCAFEF00D;
    step(4'b0011, 4'b0010, d);
    step(4'b0011, 4'b0000, rand_data());

    // Readies on non-requested channels are ignored.
    step(4'b0001, 4'b0010, rand_data());
    step(4'b0001, 4'b0010, rand_data());
    step(4'b0001, 4'b0011, rand_data());
    step(4'b0000, 4'b0000, rand_data());

    // Four channels finishing in two pairs, single ACK.
    step(4'b1111, 4'b0000, rand_data());
    step(4'b1111, 4'b0000, rand_data());
    step(4'b1111, 4'b0011, rand_data());
    step(4'b0000, 4'b0000, rand_data());
    step(4'b0000, 4'b0000, rand_data());
    step(4'b1010, 4'b1100, rand_data());
    step(4'b0000, 4'b0000, rand_data());

    // Channel 1 never answers: watchdog (if built in) ends the wait.
    if (TO_EN) begin
      step(4'b0011, 4'b0001, rand_data());
      for (int i = 0; i < TO + 2; i++) step(4'b0011, 4'b0001, rand_data());
    end

    // Reset in the middle of a wait aborts silently.
    step(4'b1111, 4'b0000, rand_data());
    step(4'b1111, 4'b0001, rand_data());
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("midrst_bus_req", 64'(bus_req_o), 64'(0));
    chk("midrst_mem_ready", 64'(mem_ready_o), 64'(0));
    chk("midrst_err", 64'(err_o), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    step(4'b0000, 4'b1111, rand_data());
    step(4'b0000, 4'b0000, rand_data());

    // Random traffic; CPU requests change freely, including while stalled.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      step(r, N'($urandom), rand_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
